// File: rtl/fetch_aligner.sv
// RV32IC instruction-fetch aligner: turns 32-bit memory words into one aligned
// 16- or 32-bit instruction per handoff, with stall hold and redirect flush.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        Stall_i,
  input  logic        Redirect_i,
  input  logic [31:0] RedirectPC_i,
  output logic        IMem_req_o,
  output logic [31:0] IMem_addr_o,
  input  logic        IMem_valid_i,
  input  logic [31:0] IMem_data_i,
  output logic        Valid_o,
  output logic [31:0] Inst_o,
  output logic [31:0] PC_o,
  output logic        Compressed_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [15:0] hb_q, hb_d;
  logic        hb_valid_q, hb_valid_d;
  logic [31:0] rr_q, rr_d;
  logic        rr_valid_q, rr_valid_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        comp_q, comp_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic        resp_live, word_avail, slot_free, consumed, emit;
  logic [31:0] word, emit_inst, emit_pc, next_word;

  function automatic logic is_comp(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    hb_d       = hb_q;
    hb_valid_d = hb_valid_q;
    rr_d       = rr_q;
    rr_valid_d = rr_valid_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    comp_d     = comp_q;
    req_d      = 1'b0;
    addr_d     = addr_q;
    consumed   = 1'b0;
    emit       = 1'b0;
    emit_inst  = '0;
    emit_pc    = fpc_q;
    next_word  = fpc_q;

    resp_live  = (state_q == S_WAIT) && IMem_valid_i;
    word_avail = rr_valid_q || resp_live;
    word       = rr_valid_q ? rr_q : IMem_data_i;
    slot_free  = !valid_q || !Stall_i;

    if (Redirect_i) begin
      valid_d    = 1'b0;
      hb_valid_d = 1'b0;
      rr_valid_d = 1'b0;
      fpc_d      = RedirectPC_i & ~32'h1;
      // A request still in flight (WAIT or DROP) must have its response discarded.
      state_d    = ((state_q != S_IDLE) && !IMem_valid_i) ? S_DROP : S_IDLE;
    end else begin
      if (IMem_valid_i && (state_q != S_IDLE)) state_d = S_IDLE;
      if (slot_free) begin
        valid_d = 1'b0;
        if (hb_valid_q && is_comp(hb_q)) begin
          emit       = 1'b1;
          emit_inst  = {16'h0000, hb_q};
          fpc_d      = fpc_q + 32'd2;
          hb_valid_d = 1'b0;
        end else if (word_avail) begin
          consumed   = 1'b1;
          rr_valid_d = 1'b0;
          if (hb_valid_q) begin
            emit      = 1'b1;
            emit_inst = {word[15:0], hb_q};
            hb_d      = word[31:16];
            fpc_d     = fpc_q + 32'd4;
          end else if (!fpc_q[1]) begin
            emit = 1'b1;
            if (is_comp(word[15:0])) begin
              emit_inst  = {16'h0000, word[15:0]};
              hb_d       = word[31:16];
              hb_valid_d = 1'b1;
              fpc_d      = fpc_q + 32'd2;
            end else begin
              emit_inst = word;
              fpc_d     = fpc_q + 32'd4;
            end
          end else if (is_comp(word[31:16])) begin
            emit      = 1'b1;
            emit_inst = {16'h0000, word[31:16]};
            fpc_d     = fpc_q + 32'd2;
          end else begin
            // Upper half starts a straddling instruction; wait for the next word.
            hb_d       = word[31:16];
            hb_valid_d = 1'b1;
          end
        end
      end
      if (resp_live && !consumed) begin
        rr_d       = IMem_data_i;
        rr_valid_d = 1'b1;
      end
      if (emit) begin
        valid_d = 1'b1;
        inst_d  = emit_inst;
        pc_d    = emit_pc;
        comp_d  = emit_inst[1:0] != 2'b11;
      end
    end

    // Issue decision looks at the post-update state so a request leaves the
    // same edge the previous word is consumed.
    if ((state_d == S_IDLE) && !rr_valid_d && !(hb_valid_d && is_comp(hb_d))) begin
      req_d     = 1'b1;
      state_d   = S_WAIT;
      next_word = hb_valid_d ? fpc_d + 32'd2 : fpc_d;
      addr_d    = next_word & ~32'h3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the buffers
  // (hb, rr) are reset along with their valid bits so outputs are clean at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      fpc_q      <= RESET_PC & ~32'h1;
      hb_q       <= '0;
      hb_valid_q <= 1'b0;
      rr_q       <= '0;
      rr_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      comp_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      hb_q       <= hb_d;
      hb_valid_q <= hb_valid_d;
      rr_q       <= rr_d;
      rr_valid_q <= rr_valid_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      comp_q     <= comp_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign IMem_req_o   = req_q;
  assign IMem_addr_o  = addr_q;
  assign Valid_o      = valid_q;
  assign Inst_o       = inst_q;
  assign PC_o         = pc_q;
  assign Compressed_o = comp_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: a word memory model answers requests and
// every handed-off instruction is popped from an expected queue and compared.
module tb_fetch_aligner;

  logic        clk_i, rst_n_i, Stall_i, Redirect_i;
  logic [31:0] RedirectPC_i;
  logic        IMem_req_o, IMem_valid_i;
  logic [31:0] IMem_addr_o, IMem_data_i;
  logic        Valid_o, Compressed_o;
  logic [31:0] Inst_o, PC_o;

  fetch_aligner dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .Stall_i      (Stall_i),
    .Redirect_i   (Redirect_i),
    .RedirectPC_i (RedirectPC_i),
    .IMem_req_o   (IMem_req_o),
    .IMem_addr_o  (IMem_addr_o),
    .IMem_valid_i (IMem_valid_i),
    .IMem_data_i  (IMem_data_i),
    .Valid_o      (Valid_o),
    .Inst_o       (Inst_o),
    .PC_o         (PC_o),
    .Compressed_o (Compressed_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    int          cyc;   // handoff cycle, -1 when timing is not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  int          lat = 1;
  bit          rand_lat = 0;
  bit          pend = 0;
  int          cnt;
  logic [31:0] pdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic comp, input int c);
    exp_t e;
    e.inst = inst; e.pc = pc; e.comp = comp; e.cyc = c;
    exp_q.push_back(e);
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Memory model: answers `lat` cycles after the request, data captured at request time.
  initial begin
    IMem_valid_i = 1'b0;
    IMem_data_i  = '0;
    forever begin
      @(posedge clk_i); #1;
      IMem_valid_i = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          IMem_valid_i = 1'b1;
          IMem_data_i  = pdata;
          pend         = 1'b0;
        end
      end
      if (IMem_req_o) begin
        check("one_outstanding", 32'(pend), 32'h0);
        if (mem.exists(IMem_addr_o)) begin
          pend  = 1'b1;
          pdata = mem[IMem_addr_o];
          cnt   = rand_lat ? int'($urandom_range(1, 3)) : lat;
        end
      end
    end
  end

  // Handoff monitor: an instruction is taken when Valid_o=1 and Stall_i=0.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && Valid_o && !Stall_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(Valid_o), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("inst", Inst_o, e.inst);
          check("pc", PC_o, e.pc);
          check("compressed", 32'(Compressed_o), 32'(e.comp));
          if (e.cyc >= 0) check("handoff_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_cycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk_i); #1;
      guard++;
    end
  endtask

  task automatic at_neg(input int n);
    wait_cycle(n);
    @(negedge clk_i);
  endtask

  task automatic start_test(input int l);
    rst_n_i      = 1'b0;
    Stall_i      = 1'b0;
    Redirect_i   = 1'b0;
    RedirectPC_i = '0;
    mem.delete();
    exp_q.delete();
    lat      = l;
    rand_lat = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 32'(Valid_o), 32'h0);
    check("rst_req", 32'(IMem_req_o), 32'h0);
    rst_n_i = 1'b1;
  endtask

  task automatic finish_test();
    repeat (10) @(posedge clk_i);
    #2;
    check("drain", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [15:0] h;
    logic [31:0] w, pc;
    logic [15:0] halves[$];
    bit          seen;

    rst_n_i = 1'b0; Stall_i = 1'b0; Redirect_i = 1'b0; RedirectPC_i = '0;
    #1;
    check("async_rst_inst", Inst_o, 32'h0);
    check("async_rst_pc", PC_o, 32'h0);
    check("async_rst_comp", 32'(Compressed_o), 32'h0);
    check("async_rst_addr", IMem_addr_o, 32'h0);

    // Two aligned 32-bit instructions, 1-cycle memory.
    start_test(1);
    mem[32'h0] = 32'h0000_0013;
    mem[32'h4] = 32'h0010_0093;
    push(32'h0000_0013, 32'h0, 1'b0, 3);
    push(32'h0010_0093, 32'h4, 1'b0, 5);
    at_neg(1);
    check("first_req", 32'(IMem_req_o), 32'h1);
    check("first_addr", IMem_addr_o, 32'h0);
    finish_test();

    // One word holding two compressed halves: second needs no request.
    start_test(1);
    mem[32'h0] = 32'h0001_4501;
    push(32'h0000_4501, 32'h0, 1'b1, 3);
    push(32'h0000_0001, 32'h2, 1'b1, 4);
    at_neg(3);
    check("no_req_for_hb", 32'(IMem_req_o), 32'h0);
    at_neg(4);
    check("req_after_hb", IMem_addr_o, 32'h4);
    finish_test();

    // Straddling 32-bit instruction, 3-cycle memory.
    start_test(3);
    mem[32'h0] = 32'h0093_4501;
    mem[32'h4] = 32'hABCD_0000;
    push(32'h0000_4501, 32'h0, 1'b1, 5);
    push(32'h0000_0093, 32'h2, 1'b0, 9);
    push(32'h0000_ABCD, 32'h6, 1'b1, 10);
    at_neg(5);
    check("straddle_addr", IMem_addr_o, 32'h4);
    finish_test();

    // Stall for 3 cycles; the response during the stall parks in rr.
    start_test(1);
    mem[32'h0] = 32'h0000_0013;
    mem[32'h4] = 32'h0010_0093;
    push(32'h0000_0013, 32'h0, 1'b0, 6);
    push(32'h0010_0093, 32'h4, 1'b0, 7);
    for (int c = 3; c <= 5; c++) begin
      wait_cycle(c);
      Stall_i = 1'b1;
      @(negedge clk_i);
      check("hold_valid", 32'(Valid_o), 32'h1);
      check("hold_inst", Inst_o, 32'h0000_0013);
      check("hold_pc", PC_o, 32'h0);
    end
    wait_cycle(6);
    Stall_i = 1'b0;
    finish_test();

    // Redirect during WAIT: in-flight response dropped, target mid-word.
    start_test(3);
    mem[32'h0]   = 32'h0000_0013;
    mem[32'h100] = 32'h4505_0013;
    push(32'h0000_4505, 32'h102, 1'b1, 9);
    wait_cycle(2);
    Redirect_i = 1'b1; RedirectPC_i = 32'h102;
    wait_cycle(3);
    Redirect_i = 1'b0;
    @(negedge clk_i);
    check("drop_no_req", 32'(IMem_req_o), 32'h0);
    at_neg(5);
    check("redir_req", 32'(IMem_req_o), 32'h1);
    check("redir_addr", IMem_addr_o, 32'h100);
    finish_test();

    // Redirect and Stall together while Valid_o=1: redirect wins.
    start_test(1);
    mem[32'h0]   = 32'h0000_0013;
    mem[32'h4]   = 32'h0010_0093;
    mem[32'h200] = 32'h0000_0013;
    push(32'h0000_0013, 32'h200, 1'b0, 7);
    wait_cycle(3);
    Stall_i = 1'b1; Redirect_i = 1'b1; RedirectPC_i = 32'h201;
    wait_cycle(4);
    Stall_i = 1'b0; Redirect_i = 1'b0;
    @(negedge clk_i);
    check("flush_valid", 32'(Valid_o), 32'h0);
    at_neg(5);
    check("flush_req_addr", IMem_addr_o, 32'h200);
    finish_test();

    // Odd redirect target whose upper half opens a straddling instruction.
    start_test(1);
    mem[32'h0]  = 32'h0000_0013;
    mem[32'h10] = 32'h0093_0001;
    mem[32'h14] = 32'h4501_0000;
    push(32'h0000_0093, 32'h12, 1'b0, 7);
    push(32'h0000_4501, 32'h16, 1'b1, 8);
    wait_cycle(1);
    Redirect_i = 1'b1; RedirectPC_i = 32'h13;
    wait_cycle(2);
    Redirect_i = 1'b0;
    at_neg(5);
    check("upper_straddle_addr", IMem_addr_o, 32'h14);
    finish_test();

    // Reset mid-WAIT: outputs clear without a clock; the late response is ignored.
    start_test(1);
    mem[32'h0] = 32'h0000_0013;
    mem[32'h4] = 32'h0010_0093;
    push(32'h0000_0013, 32'h0, 1'b0, 3);
    wait_cycle(2);
    lat = 4;
    at_neg(3);
    #2;
    check("pre_rst_req", 32'(IMem_req_o), 32'h1);
    check("pre_rst_addr", IMem_addr_o, 32'h4);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(Valid_o), 32'h0);
    check("mid_rst_inst", Inst_o, 32'h0);
    check("mid_rst_pc", PC_o, 32'h0);
    check("mid_rst_comp", 32'(Compressed_o), 32'h0);
    check("mid_rst_req", 32'(IMem_req_o), 32'h0);
    check("mid_rst_addr", IMem_addr_o, 32'h0);
    mem.delete(32'h4);
    mem[32'h0] = 32'h0000_4501;
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk_i); #2;
      seen = IMem_valid_i;
    end
    check("stale_resp_seen", 32'(seen), 32'h1);
    rst_n_i = 1'b1;
    push(32'h0000_4501, 32'h0, 1'b1, 3);
    push(32'h0000_0000, 32'h2, 1'b1, 4);
    at_neg(1);
    check("post_rst_req", 32'(IMem_req_o), 32'h1);
    check("post_rst_addr", IMem_addr_o, 32'h0);
    finish_test();

    // Random mixed-length program with random latency and random stalls.
    start_test(1);
    rand_lat = 1'b1;
    pc = 32'h0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        h = 16'($urandom);
        h[1:0] = 2'($urandom_range(0, 2));
        halves.push_back(h);
        push({16'h0000, h}, pc, 1'b1, -1);
        pc = pc + 32'd2;
      end else begin
        w = $urandom;
        w[1:0] = 2'b11;
        halves.push_back(w[15:0]);
        halves.push_back(w[31:16]);
        push(w, pc, 1'b0, -1);
        pc = pc + 32'd4;
      end
    end
    if (halves.size() % 2 == 1) begin
      halves.push_back(16'h0001);
      push(32'h0000_0001, pc, 1'b1, -1);
    end
    for (int i = 0; i < halves.size() / 2; i++)
      mem[32'(4 * i)] = {halves[2 * i + 1], halves[2 * i]};
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      Stall_i = ($urandom_range(0, 3) == 0);
    end
    Stall_i = 1'b0;
    finish_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
